// File: rtl/dm_responder.sv
// Data-memory responder: valid/ready load/store port in front of a byte-addressed RAM, big-endian within an access.
// Optional `DM_RESP_ERR_EN: flags misaligned, invalid-dop and out-of-range accesses instead of performing them.
module dm_responder #(
  parameter int DEPTH_BYTES = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_dop,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q;
  logic [2:0]    dop_q;
  logic [31:0]   addr_q, wdata_q;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q;
  logic [7:0]    mem [DEPTH_BYTES];

  logic          accept, access;
  logic          a_we;
  logic [2:0]    a_dop;
  logic [31:0]   a_addr, a_wdata;
  logic [1:0]    sz;
  logic          bad, err_c, fault;
  logic [AW-1:0] i0, i1, i2, i3;
  logic [7:0]    b0, b1, b2, b3;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
        cnt_d   = '0;
      end
      S_WAIT: if (cnt_q == CNT_LAST) begin
        state_d = S_RESP;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      S_IDLE:  req_ready = !rst;
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign accept = req_valid && req_ready;
  // The access happens on the edge that enters RESP; with zero wait states that is the accept edge itself.
  assign access = (state_d == S_RESP) && (state_q != S_RESP);

  // ---------------- request latch ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      dop_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      dop_q   <= req_dop;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  assign a_we    = (state_q == S_IDLE) ? req_we    : we_q;
  assign a_dop   = (state_q == S_IDLE) ? req_dop   : dop_q;
  assign a_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
  assign a_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;

  // ---------------- decode ----------------
  assign sz  = a_dop[1:0];
  assign bad = (sz == 2'd3) || (a_dop[2] && (a_we || sz == 2'd2));

`ifdef DM_RESP_ERR_EN
  logic misal, oor;
  assign misal = (sz == 2'd1 && a_addr[0]) || (sz == 2'd2 && a_addr[1:0] != 2'b00);
  assign oor   = |a_addr[31:AW];
  assign err_c = bad || misal || oor;
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^a_addr[31:AW];
  assign err_c = 1'b0;
`endif

  assign fault = bad || err_c;

  // Index arithmetic is AW bits wide so multi-byte accesses wrap around the RAM.
  assign i0 = a_addr[AW-1:0];
  assign i1 = i0 + AW'(1);
  assign i2 = i0 + AW'(2);
  assign i3 = i0 + AW'(3);
  assign b0 = mem[i0];
  assign b1 = mem[i1];
  assign b2 = mem[i2];
  assign b3 = mem[i3];

  always_comb begin
    rdata_d = '0;
    if (!a_we && !fault) begin
      case (a_dop)
        3'd0:    rdata_d = {{24{b0[7]}}, b0};
        3'd1:    rdata_d = {{16{b0[7]}}, b0, b1};
        3'd2:    rdata_d = {b0, b1, b2, b3};
        3'd4:    rdata_d = {24'd0, b0};
        3'd5:    rdata_d = {16'd0, b0, b1};
        default: rdata_d = '0;
      endcase
    end
  end

  // ---------------- RAM and response ----------------
  always_ff @(posedge clk) begin
    if (access && a_we && !fault) begin
      case (sz)
        2'd0: mem[i0] <= a_wdata[7:0];
        2'd1: begin
          mem[i0] <= a_wdata[15:8];
          mem[i1] <= a_wdata[7:0];
        end
        default: begin
          mem[i0] <= a_wdata[31:24];
          mem[i1] <= a_wdata[23:16];
          mem[i2] <= a_wdata[15:8];
          mem[i3] <= a_wdata[7:0];
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (access) begin
      rdata_q <= rdata_d;
      err_q   <= err_c;
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
